// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving an external 1-bit full-adder cell.
// Operands are captured on start; one bit is processed per clock, LSB first.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_o,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             run;

    // Cell inputs are only presented while a bit is being processed
    assign run   = (state_q == S_RUN);
    assign fa_a  = run & a_q[cnt_q];
    assign fa_b  = run & b_q[cnt_q];
    assign fa_ci = run & carry_q;

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // Next-state: capture on start, one bit per cycle, single-cycle done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[cnt_q] = fa_o;
                carry_d      = fa_co;
                if (cnt_q == LAST) begin
                    // Overflow: carry into MSB differs from carry out of it
                    cout_d  = fa_co;
                    ovf_d   = fa_ci ^ fa_co;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with an ideal full-adder cell.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         fa_a, fa_b, fa_ci, fa_o, fa_co;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_o(fa_o), .fa_co(fa_co),
        .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Ideal combinational full-adder cell
    assign fa_o  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_done = 0;

    // Expected {cout, ovf, sum} and accept-edge index per operation
    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    logic [W+1:0] e_m;
    int           t_m;
    logic         prev_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {s[W], ov, s[W-1:0]};
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 required none");
                end else begin
                    e_m = exp_q.pop_front();
                    t_m = acc_q.pop_front();
                    check("result", {cout, ovf, sum}, e_m);
                    check("latency", cyc - t_m, W);
                end
                check("done_one_cycle", prev_done, 0);
            end
            if (!busy) check("fa_idle", {fa_a, fa_b, fa_ci}, 0);
        end
        prev_done = done;
    end

    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W+1:0] e);
        int g = 0;
        @(negedge clk);
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: got busy=1 required 0");
            return;
        end
        start = 1'b1;
        a = x;
        b = y;
        cin = c;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        n_acc++;
        start = 1'b0;
        a = ~x;
        b = ~y;
        cin = ~c;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got pending=%0d required 0",
                     exp_q.size());
        end
    endtask

    initial begin
        int g;
        int d0;
        logic [W-1:0] x, y;
        logic c;

        #12;
        check("reset_outs",
              {busy, done, fa_a, fa_b, fa_ci, cout, ovf, sum}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_add(8'h0F, 8'h01, 1'b0, 10'h010);
        // Start pulses with other operands during RUN and DONE
        start = 1'b1;
        a = 8'h11;
        b = 8'h11;
        cin = 1'b1;
        g = 0;
        while (!done && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", done, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_drop", busy, 0);
        repeat (W + 3) @(negedge clk);
        check("ignored_busy", busy, 0);
        check("sum_hold", {cout, ovf, sum}, 10'h010);

        do_add(8'hFF, 8'h01, 1'b0, 10'h200);
        do_add(8'hFF, 8'h00, 1'b1, 10'h200);
        do_add(8'h7F, 8'h01, 1'b0, 10'h180);
        do_add(8'h80, 8'h80, 1'b0, 10'h300);
        wait_drain();

        // Abort mid-run at cnt=4
        do_add(8'hFF, 8'h00, 1'b0, 10'h0FF);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outs",
              {busy, done, fa_a, fa_b, fa_ci, cout, ovf, sum}, 0);
        exp_q.delete();
        acc_q.delete();
        n_acc--;
        d0 = n_done;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("no_done_after_rst", n_done, d0);
        do_add(8'h03, 8'h05, 1'b0, 10'h008);
        wait_drain();

        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            do_add(x, y, c, model(x, y, c));
        end
        wait_drain();
        check("done_count", n_done, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
